// File: rtl/rx_packet_parser_pkg.sv
// Shared definitions for the RX packet parser: FSM state encoding,
// default frame start marker and checksum arithmetic.
package rx_packet_parser_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         CHK_W         = 8;

   typedef logic [CHK_W-1:0] chk_t;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHECK   = 3'd3,
      ST_SEND    = 3'd4
   } state_t;

   // Running checksum update; wraps modulo 2**CHK_W.
   function automatic chk_t chk_add(input chk_t acc, input logic [7:0] b);
      return acc + chk_t'(b);
   endfunction

endpackage

// File: rtl/rx_packet_parser_if.sv
// Byte stream bundle: UART receive side in, payload stream out.
interface rx_packet_parser_if;

   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;

   // Parser side of the bundle.
   modport slave (
      input  rx_data, rx_done_tick, m_ready,
      output m_data, m_valid, m_last
   );

   // Environment side: byte source and payload consumer.
   modport master (
      output rx_data, rx_done_tick, m_ready,
      input  m_data, m_valid, m_last
   );

endinterface

// File: rtl/rx_pkt_buf.sv
// Payload store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module rx_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // Write one payload byte per strobe.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_packet_parser.sv
// Frame parser: SYNC, LEN, LEN payload bytes, CHK. Good frames are
// buffered and replayed on a valid/ready stream; bad frames raise a
// one-cycle error pulse and are never output.
module rx_packet_parser
   import rx_packet_parser_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic                clk,
   input  logic                rst,
   rx_packet_parser_if.slave   bus,
   output logic                err_chk,
   output logic                err_len,
   output logic                err_tout,
   output logic                err_ovr,
   output logic [15:0]         good_cnt
);

   localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [7:0]  len_q, len_d;
   chk_t        sum_q, sum_d;
   logic [7:0]  wr_idx_q, wr_idx_d;
   logic [7:0]  rd_idx_q, rd_idx_d;
   logic [15:0] good_q, good_d;
   logic [31:0] tout_q, tout_d;
   logic        err_chk_q, err_chk_d;
   logic        err_len_q, err_len_d;
   logic        err_tout_q, err_tout_d;
   logic        err_ovr_q, err_ovr_d;
   logic        buf_we_s;
   logic [7:0]  rd_data_s;
   logic        tout_hit_s;
   logic        rd_last_s;

   rx_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
      .clk     (clk),
      .we_i    (buf_we_s),
      .waddr_i (wr_idx_q[AW-1:0]),
      .wdata_i (bus.rx_data),
      .raddr_i (rd_idx_q[AW-1:0]),
      .rdata_o (rd_data_s)
   );

   assign tout_hit_s = (tout_q == TOUT_LAST);
   assign rd_last_s  = (rd_idx_q == (len_q - 8'd1));

   // Next-state, datapath updates and error detection.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      sum_d      = sum_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      good_d     = good_q;
      err_chk_d  = 1'b0;
      err_len_d  = 1'b0;
      err_tout_d = 1'b0;
      err_ovr_d  = 1'b0;
      buf_we_s   = 1'b0;
      tout_d     = 32'd0;

      case (state_q)
         ST_HUNT: begin
            if (bus.rx_done_tick && (bus.rx_data == SYNC_BYTE)) begin
               state_d = ST_LEN;
            end else begin
               state_d = ST_HUNT;
            end
         end
         ST_LEN: begin
            if (bus.rx_done_tick) begin
               if ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B)) begin
                  err_len_d = 1'b1;
                  state_d   = ST_HUNT;
               end else begin
                  len_d    = bus.rx_data;
                  sum_d    = chk_t'(bus.rx_data);
                  wr_idx_d = 8'd0;
                  state_d  = ST_PAYLOAD;
               end
            end else if (tout_hit_s) begin
               err_tout_d = 1'b1;
               state_d    = ST_HUNT;
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_PAYLOAD: begin
            if (bus.rx_done_tick) begin
               buf_we_s = 1'b1;
               sum_d    = chk_add(sum_q, bus.rx_data);
               wr_idx_d = wr_idx_q + 8'd1;
               if (wr_idx_q == (len_q - 8'd1)) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end else if (tout_hit_s) begin
               err_tout_d = 1'b1;
               state_d    = ST_HUNT;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_CHECK: begin
            if (bus.rx_done_tick) begin
               if (bus.rx_data == sum_q) begin
                  good_d   = good_q + 16'd1;
                  rd_idx_d = 8'd0;
                  state_d  = ST_SEND;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = ST_HUNT;
               end
            end else if (tout_hit_s) begin
               err_tout_d = 1'b1;
               state_d    = ST_HUNT;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_SEND: begin
            // Incoming bytes cannot be stored while the buffer drains.
            if (bus.rx_done_tick) begin
               err_ovr_d = 1'b1;
            end else begin
               err_ovr_d = 1'b0;
            end
            if (bus.m_ready) begin
               if (rd_last_s) begin
                  state_d = ST_HUNT;
               end else begin
                  rd_idx_d = rd_idx_q + 8'd1;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      // Inter-byte timer: only runs while a frame is being received.
      if (bus.rx_done_tick || (state_d != state_q)) begin
         tout_d = 32'd0;
      end else if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK)) begin
         tout_d = tout_q + 32'd1;
      end else begin
         tout_d = 32'd0;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HUNT;
         len_q      <= 8'd0;
         sum_q      <= '0;
         wr_idx_q   <= 8'd0;
         rd_idx_q   <= 8'd0;
         good_q     <= 16'd0;
         tout_q     <= 32'd0;
         err_chk_q  <= 1'b0;
         err_len_q  <= 1'b0;
         err_tout_q <= 1'b0;
         err_ovr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         sum_q      <= sum_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         good_q     <= good_d;
         tout_q     <= tout_d;
         err_chk_q  <= err_chk_d;
         err_len_q  <= err_len_d;
         err_tout_q <= err_tout_d;
         err_ovr_q  <= err_ovr_d;
      end
   end

   // Stream outputs derive only from registered state, so they are
   // quiet (all zero) outside SEND and immediately on reset.
   assign bus.m_valid = (state_q == ST_SEND);
   assign bus.m_data  = (state_q == ST_SEND) ? rd_data_s : 8'd0;
   assign bus.m_last  = (state_q == ST_SEND) && rd_last_s;

   assign err_chk  = err_chk_q;
   assign err_len  = err_len_q;
   assign err_tout = err_tout_q;
   assign err_ovr  = err_ovr_q;
   assign good_cnt = good_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Self-checking bench for rx_packet_parser: directed frames plus random
// frames scored against a frame-level reference model.
module tb_rx_packet_parser;

   localparam int MAX_LEN = 16;
   localparam int TOUT    = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_chk, err_len, err_tout, err_ovr;
   logic [15:0] good_cnt;

   rx_packet_parser_if bus();

   rx_packet_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .err_chk  (err_chk),
      .err_len  (err_len),
      .err_tout (err_tout),
      .err_ovr  (err_ovr),
      .good_cnt (good_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Observed stream and error pulses; expected counterparts from the model.
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];
   int n_chk = 0, n_len = 0, n_tout = 0, n_ovr = 0, n_valid = 0;
   int e_chk = 0, e_len = 0, e_tout = 0, e_ovr = 0;
   int exp_good = 0;
   int rdy_mode = 1;
   logic [7:0] fr_q[$];

   // Monitor: sample on the falling edge.
   initial begin
      logic       hold_prev;
      logic [7:0] data_prev;
      hold_prev = 1'b0;
      data_prev = 8'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_prev = 1'b0;
         end else begin
            if (err_chk)  n_chk++;
            if (err_len)  n_len++;
            if (err_tout) n_tout++;
            if (err_ovr)  n_ovr++;
            if (bus.m_valid) begin
               n_valid++;
               if (hold_prev) check("hold_stable", 32'(bus.m_data), 32'(data_prev));
            end
            if (bus.m_valid && bus.m_ready) got_q.push_back({bus.m_last, bus.m_data});
            hold_prev = bus.m_valid && !bus.m_ready;
            data_prev = bus.m_data;
         end
      end
   end

   // Consumer: always ready, never ready, or random.
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data      = b;
      bus.rx_done_tick = 1'b1;
      @(posedge clk); #1;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'($urandom);
   endtask

   // Reference model: outcome of one frame held in fr_q, from the frame rules.
   task automatic model_frame();
      int len;
      int sum;
      len = int'(fr_q[1]);
      if (len == 0 || len > MAX_LEN) begin
         e_len++;
      end else begin
         sum = len;
         for (int i = 0; i < len; i++) sum += int'(fr_q[2+i]);
         if (int'(fr_q[2+len]) == (sum % 256)) begin
            for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fr_q[2+i]});
            exp_good = (exp_good + 1) % 65536;
         end else begin
            e_chk++;
         end
      end
   endtask

   task automatic make_frame(input int len, input bit good);
      int sum;
      logic [7:0] b;
      fr_q.delete();
      fr_q.push_back(8'hA5);
      fr_q.push_back(8'(len));
      if (len >= 1 && len <= MAX_LEN) begin
         sum = len;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fr_q.push_back(b);
            sum += int'(b);
         end
         b = 8'(sum % 256);
         if (!good) b = b ^ 8'($urandom_range(1, 255));
         fr_q.push_back(b);
      end
   endtask

   task automatic send_frame();
      model_frame();
      foreach (fr_q[i]) send_byte(fr_q[i]);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!bus.m_valid) break;
      end
      check("drain_bound", 32'(bus.m_valid), 32'd0);
   endtask

   task automatic compare_sb(input string tag);
      check($sformatf("%s_out_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_out_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      check($sformatf("%s_err_chk", tag),  32'(n_chk),  32'(e_chk));
      check($sformatf("%s_err_len", tag),  32'(n_len),  32'(e_len));
      check($sformatf("%s_err_tout", tag), 32'(n_tout), 32'(e_tout));
      check($sformatf("%s_err_ovr", tag),  32'(n_ovr),  32'(e_ovr));
      check($sformatf("%s_good_cnt", tag), 32'(good_cnt), 32'(exp_good));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      int len;
      logic [7:0] g;
      rst = 1'b1;
      bus.rx_data = 8'd0;
      bus.rx_done_tick = 1'b0;
      rdy_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("rst_m_last",  32'(bus.m_last),  32'd0);
      check("rst_m_data",  32'(bus.m_data),  32'd0);
      check("rst_errs",    32'({err_chk, err_len, err_tout, err_ovr}), 32'd0);
      check("rst_good",    32'(good_cnt), 32'd0);

      // Basic frame, consumer always ready: bytes on consecutive cycles.
      fr_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      send_frame();
      check("b_valid0", 32'(bus.m_valid), 32'd1);
      check("b_data0",  32'(bus.m_data),  32'h11);
      check("b_last0",  32'(bus.m_last),  32'd0);
      @(posedge clk); #1;
      check("b_data1",  32'(bus.m_data),  32'h22);
      check("b_last1",  32'(bus.m_last),  32'd0);
      @(posedge clk); #1;
      check("b_data2",  32'(bus.m_data),  32'h33);
      check("b_last2",  32'(bus.m_last),  32'd1);
      @(posedge clk); #1;
      check("b_valid_end", 32'(bus.m_valid), 32'd0);
      check("b_good", 32'(good_cnt), 32'd1);
      wait_idle();
      compare_sb("basic");

      // Checksum mismatch: nothing is output.
      nv = n_valid;
      fr_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
      send_frame();
      repeat (5) @(negedge clk);
      check("chk_no_valid", 32'(n_valid), 32'(nv));
      compare_sb("chkerr");

      // Illegal lengths, then a good frame proves the FSM is hunting.
      fr_q = '{8'hA5, 8'h00};
      send_frame();
      fr_q = '{8'hA5, 8'h11};
      send_frame();
      fr_q = '{8'hA5, 8'h01, 8'h42, 8'h43};
      send_frame();
      wait_idle();
      compare_sb("lenerr");

      // Inter-byte timeout mid-payload, then recovery.
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      repeat (TOUT + 5) @(posedge clk);
      e_tout++;
      make_frame(3, 1'b1);
      send_frame();
      wait_idle();
      compare_sb("tout");

      // Byte arriving in the very cycle the timer expires wins.
      make_frame(2, 1'b1);
      model_frame();
      send_byte(fr_q[0]); send_byte(fr_q[1]);
      repeat (TOUT - 2) @(posedge clk);
      for (int i = 2; i < fr_q.size(); i++) send_byte(fr_q[i]);
      wait_idle();
      compare_sb("tout_edge_ok");

      // One cycle later the timeout fires and the late byte is discarded.
      send_byte(8'hA5); send_byte(8'h01);
      repeat (TOUT - 1) @(posedge clk);
      send_byte(8'h42);
      e_tout++;
      repeat (3) @(negedge clk);
      compare_sb("tout_edge_late");

      // Back-pressure with an overrun byte during SEND.
      rdy_mode = 0;
      fr_q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
      send_frame();
      repeat (3) @(posedge clk);
      send_byte(8'h55);
      e_ovr++;
      repeat (4) @(posedge clk);
      #1;
      check("ovr_valid", 32'(bus.m_valid), 32'd1);
      check("ovr_data",  32'(bus.m_data),  32'hAA);
      rdy_mode = 1;
      wait_idle();
      compare_sb("ovr");

      // Reset in the middle of a payload aborts the frame.
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
      check("mid_rst_last",  32'(bus.m_last),  32'd0);
      check("mid_rst_data",  32'(bus.m_data),  32'd0);
      check("mid_rst_errs",  32'({err_chk, err_len, err_tout, err_ovr}), 32'd0);
      check("mid_rst_good",  32'(good_cnt), 32'd0);
      exp_good = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      fr_q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
      send_frame();
      wait_idle();
      compare_sb("rst_recover");

      // Random frames with random back-pressure and inter-frame garbage.
      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
         end
         len = $urandom_range(0, MAX_LEN + 2);
         make_frame(len, ($urandom_range(0, 3) != 0));
         send_frame();
         wait_idle();
      end
      compare_sb("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_packet_parser.md
RX_PACKET_PARSER -- requirements
Module: rx_packet_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum payload bytes, range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: idle clk cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port rx_data, input, 8: received byte from the UART receiver.
REQ-007 SHALL have port rx_done_tick, input, 1: one-cycle strobe; rx_data is valid in the same cycle.
REQ-008 SHALL have port m_data, output, 8: payload byte to the anomaly detector.
REQ-009 SHALL have port m_valid, output, 1: m_data is valid.
REQ-010 SHALL have port m_last, output, 1: the current byte is the final payload byte.
REQ-011 SHALL have port m_ready, input, 1: consumer accepts the byte.
REQ-012 SHALL have port err_chk, output, 1: one-cycle pulse on checksum mismatch.
REQ-013 SHALL have port err_len, output, 1: one-cycle pulse on illegal LEN.
REQ-014 SHALL have port err_tout, output, 1: one-cycle pulse on inter-byte timeout.
REQ-015 SHALL have port err_ovr, output, 1: one-cycle pulse when a byte is dropped during SEND.
REQ-016 SHALL have port good_cnt, output, 16: count of frames accepted; wraps at 16'hFFFF -> 0.

Function
REQ-017 SHALL use the frame format SYNC, LEN, LEN payload bytes, CHK; CHK = (LEN + sum of payload) mod 256.
REQ-018 SHALL implement FSM states HUNT, LEN, PAYLOAD, CHECK, SEND.
REQ-019 HUNT SHALL go to LEN on rx_done_tick with rx_data == SYNC_BYTE; all other bytes are discarded silently.
REQ-020 LEN SHALL, on a legal byte (LEN in 1..MAX_LEN), store LEN, seed the sum with LEN, clear the write index, and go to PAYLOAD.
REQ-021 LEN SHALL, on 0 or >MAX_LEN, pulse err_len and go to HUNT.
REQ-022 PAYLOAD SHALL write each byte to buffer[index], add it to the sum with 8-bit wrap, and go to CHECK once the LEN-th byte is stored.
REQ-023 CHECK SHALL, on a byte equal to the sum, increment good_cnt, clear the read index, and go to SEND.
REQ-024 CHECK SHALL, on a mismatch, pulse err_chk and go to HUNT; the buffer is never output.
REQ-025 SEND SHALL drive m_valid=1 with m_data=buffer[read index]; the byte transfers when m_valid && m_ready.
REQ-026 SEND SHALL hold m_data stable while m_valid && !m_ready.
REQ-027 m_last SHALL be 1 exactly when the read index equals LEN-1.
REQ-028 SEND SHALL go to HUNT in the cycle after the last byte transfers, with m_valid low.
REQ-029 The first m_valid SHALL assert in the cycle after the CHK byte strobe.
REQ-030 Any rx_done_tick during SEND SHALL be dropped with an err_ovr pulse; no state change results.
REQ-031 The timeout counter SHALL clear on every rx_done_tick and on every state entry, and count clk cycles in LEN, PAYLOAD and CHECK only.
REQ-032 When the timeout counter reaches TIMEOUT_CYC-1 with no rx_done_tick in that cycle, the block SHALL pulse err_tout and go to HUNT.
REQ-033 When a byte strobe and a timeout coincide, the byte SHALL win and no timeout is flagged.
REQ-034 Error pulses SHALL be registered outputs, high for exactly one cycle.

Reset
REQ-035 rst SHALL asynchronously force state HUNT, m_valid=0, m_last=0, m_data=0, all err_* = 0, good_cnt=0, and all indices, sum and timeout counter to 0.
REQ-036 The buffer contents need no reset.
REQ-037 Reset asserted mid-frame or mid-SEND SHALL abort the frame; nothing is output after release until a new complete frame arrives.

Structure
REQ-038 The shared package SHALL hold the state encoding, the SYNC_BYTE default and the checksum width.
REQ-039 The payload store SHALL be one sub-module, rx_pkt_buf: MAX_LEN x 8, one synchronous write port, one asynchronous read port.

Verification
REQ-040 Bench SHALL drive A5 03 11 22 33 69 and then hold m_ready=1 -> m_data 11,22,33 on consecutive cycles, m_last on 33, good_cnt=1.
REQ-041 Bench SHALL drive A5 02 10 20 00 -> err_chk pulse, m_valid never asserts, good_cnt unchanged.
REQ-042 Bench SHALL drive A5 00 and then A5 11 (with MAX_LEN=16) -> two err_len pulses, FSM in HUNT.
REQ-043 Bench SHALL drive A5 03 11, then no strobe for TIMEOUT_CYC cycles -> one err_tout pulse, then a valid frame parses correctly.
REQ-044 Bench SHALL hold a valid frame with m_ready=0 for 10 cycles while strobing byte 55 -> m_data stable, one err_ovr pulse, full payload delivered after m_ready=1.
REQ-045 Bench SHALL assert rst during PAYLOAD -> all outputs at reset values immediately, then a following A5 01 7F 80 frame is output correctly.
